// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state type, byte index helper and inverse S-box
//
// Purpose: common definitions for the AES inverse-cipher datapath blocks.
//   AES_ROWS/AES_COLS : state geometry (4x4 bytes)
//   aes_state_t       : 128-bit state, row r in bits [127-32r : 96-32r],
//                       column 0 is the MSB byte of each row
//   INV_SBOX          : standard AES inverse S-box, indexed by input byte
//   byte_lsb()        : bit offset of the LSB of byte (row, col)
package aes_pkg;

  localparam int AES_ROWS = 4;
  localparam int AES_COLS = 4;

  typedef logic [127:0] aes_state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Rows are 32-bit words stacked MSB-first; column 0 is the MSB byte of a row.
  function automatic int byte_lsb(input int row, input int col);
    return 120 - 32 * row - 8 * col;
  endfunction

endpackage

// File: rtl/inv_shift_sub_stage_if.sv
// rtl/inv_shift_sub_stage_if.sv - valid/ready stream of AES states with a last sideband
//
// Purpose: one direction of the state stream.
//   valid : state present
//   ready : sink accepts this cycle
//   data  : 128-bit AES state
//   last  : sideband flag travelling with the state
// Modports: master drives valid/data/last, slave drives ready.
interface inv_shift_sub_stage_if;
  import aes_pkg::*;

  logic       valid;
  logic       ready;
  aes_state_t data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - combinational InvSubBytes over a 128-bit AES state
//
// Purpose: 16 independent inverse S-box lookups.
//   in_state  : state before substitution
//   out_state : each byte replaced by INV_SBOX[byte]
module inv_sub_bytes
  import aes_pkg::*;
(
  input  aes_state_t in_state,
  output aes_state_t out_state
);

  always_comb begin
    out_state = '0;
    for (int i = 0; i < 16; i++) begin
      out_state[8*i +: 8] = INV_SBOX[in_state[8*i +: 8]];
    end
  end

endmodule

// File: rtl/inv_shift_sub_stage.sv
// rtl/inv_shift_sub_stage.sv - elastic InvShiftRows + InvSubBytes pipeline stage
//
// Purpose: S1 registers InvShiftRows(in) and S2 registers InvSubBytes(S1),
// each with a valid flag; a stage loads when empty or when its successor loads.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   in_if  : slave stream (valid/ready/data/last) from the previous round step
//   out_if : master stream of transformed states
// Configuration macro AES_INV_SBOX_EN: when defined, the full two-stage pipeline
// (latency 2); when undefined, InvSubBytes and S2 are dropped and the output is
// S1 (InvShiftRows only, latency 1).
module inv_shift_sub_stage
  import aes_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  inv_shift_sub_stage_if.slave          in_if,
  inv_shift_sub_stage_if.master         out_if
);

  aes_state_t isr_data;
  logic       in_xfer;
  logic       load1;

  logic       v1_q, v1_d;
  aes_state_t s1_data_q, s1_data_d;
  logic       s1_last_q, s1_last_d;

  // InvShiftRows: output byte (r, c) comes from input byte (r, c - r mod 4),
  // i.e. each row is rotated right by r bytes.
  always_comb begin
    isr_data = '0;
    for (int r = 0; r < AES_ROWS; r++) begin
      for (int c = 0; c < AES_COLS; c++) begin
        isr_data[byte_lsb(r, c) +: 8] =
          in_if.data[byte_lsb(r, (c + AES_COLS - r) % AES_COLS) +: 8];
      end
    end
  end

`ifdef AES_INV_SBOX_EN
  logic       load2;
  logic       v2_q, v2_d;
  aes_state_t s2_data_q, s2_data_d;
  logic       s2_last_q, s2_last_d;
  aes_state_t isb_data;

  inv_sub_bytes u_inv_sub_bytes (
    .in_state  (s1_data_q),
    .out_state (isb_data)
  );

  // Ready chain: out_ready -> load2 -> load1 -> in_ready.
  assign load2 = !v2_q || out_if.ready;
  assign load1 = !v1_q || load2;

  always_comb begin
    v2_d      = v2_q;
    s2_data_d = s2_data_q;
    s2_last_d = s2_last_q;
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_data_d = isb_data;
        s2_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q      <= 1'b0;
      s2_data_q <= '0;
      s2_last_q <= 1'b0;
    end else begin
      v2_q      <= v2_d;
      s2_data_q <= s2_data_d;
      s2_last_q <= s2_last_d;
    end
  end

  assign out_if.valid = v2_q;
  assign out_if.data  = s2_data_q;
  assign out_if.last  = s2_last_q;
`else
  assign load1 = !v1_q || out_if.ready;

  assign out_if.valid = v1_q;
  assign out_if.data  = s1_data_q;
  assign out_if.last  = s1_last_q;
`endif

  assign in_if.ready = load1;
  assign in_xfer     = in_if.valid && load1;

  always_comb begin
    v1_d      = v1_q;
    s1_data_d = s1_data_q;
    s1_last_d = s1_last_q;
    if (load1) begin
      v1_d = in_xfer;
      if (in_xfer) begin
        s1_data_d = isr_data;
        s1_last_d = in_if.last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_data_q <= '0;
      s1_last_q <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      s1_data_q <= s1_data_d;
      s1_last_q <= s1_last_d;
    end
  end

endmodule

// File: tb/tb_inv_shift_sub_stage.sv
// tb/tb_inv_shift_sub_stage.sv - self-checking bench for inv_shift_sub_stage
module tb_inv_shift_sub_stage;

`ifdef AES_INV_SBOX_EN
  localparam int LAT = 2;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  inv_shift_sub_stage_if in_if ();
  inv_shift_sub_stage_if out_if ();

  inv_shift_sub_stage dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (in_if),
    .out_if (out_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [128:0]  exp_q [$];
  logic          hold_prev = 1'b0;
  logic [127:0]  prev_data;
  logic          prev_last;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Encryption-side ShiftRows (+ SubBytes in the full build): the inverse of the DUT.
  function automatic logic [127:0] enc(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[120 - 32*r - 8*c +: 8] = x[120 - 32*r - 8*((c + r) % 4) +: 8];
`ifdef AES_INV_SBOX_EN
    for (int i = 0; i < 16; i++) y[8*i +: 8] = SBOX[y[8*i +: 8]];
`endif
    return y;
  endfunction

  // One clock of stimulus; checks in_ready, stall stability and in-order delivery.
  task automatic step(input logic iv, input logic [127:0] id, input logic il,
                      input logic ordy, input logic [127:0] exp);
    logic [128:0] e;
    @(negedge clk);
    in_if.valid  = iv;
    in_if.data   = id;
    in_if.last   = il;
    out_if.ready = ordy;
    #1;
    check("in_ready", in_if.ready, !(exp_q.size() == LAT && !ordy));
    if (hold_prev) begin
      check("stall_data", out_if.data, prev_data);
      check("stall_last", out_if.last, prev_last);
    end
    if (out_if.valid && ordy) begin
      if (exp_q.size() == 0) check("spurious_out", out_if.valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("out_data", out_if.data, e[127:0]);
        check("out_last", out_if.last, e[128]);
      end
    end
    hold_prev = out_if.valid && !ordy;
    prev_data = out_if.data;
    prev_last = out_if.last;
    if (iv && in_if.ready) exp_q.push_back({il, exp});
  endtask

  initial begin
    logic [127:0] x;
    logic         bp_pat [5];
    int           idx;
    int           cyc;
    logic         rdy;
    logic         bub_pat [5];

    rst = 1'b1;
    in_if.valid = 1'b0; in_if.data = '0; in_if.last = 1'b0; out_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_out_data",  out_if.data, 128'h0);
    check("rst_out_last",  out_if.last, 1'b0);
    check("rst_in_ready",  in_if.ready, 1'b1);

    // Directed vectors.
`ifdef AES_INV_SBOX_EN
    step(1'b1, {16{8'h63}}, 1'b1, 1'b1, {16{8'h00}});
    step(1'b1, {16{8'h00}}, 1'b0, 1'b1, {16{8'h52}});
`else
    step(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b1,
               128'h00112233_77445566_AABB8899_DDEEFFCC);
    step(1'b1, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0, 1'b1,
               128'h00010203_07040506_0A0B0809_0D0E0F0C);
`endif
    repeat (LAT + 2) step(1'b0, '0, 1'b0, 1'b1, '0);
    check("directed_drain", exp_q.size(), 0);

    // Bubbles: out_valid reproduces the in_valid pattern LAT cycles later.
    bub_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5 + LAT; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      step((i < 5) ? bub_pat[i] : 1'b0, enc(x), 1'b0, 1'b1, x);
      check("bubble_valid", out_if.valid, (i >= LAT) ? bub_pat[i - LAT] : 1'b0);
    end
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, '0);

    // Round trip at full throughput.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, enc(x), 1'(($urandom >> 3) & 1), 1'b1, x);
    end
    repeat (LAT + 2) step(1'b0, '0, 1'b0, 1'b1, '0);
    check("roundtrip_drain", exp_q.size(), 0);

    // Backpressure: 8 states, random out_ready with two forced 5-cycle holds.
    idx = 0;
    cyc = 0;
    x = {$urandom, $urandom, $urandom, $urandom};
    while ((idx < 8 || exp_q.size() != 0) && cyc < 300) begin
      if ((cyc >= 4 && cyc < 9) || (cyc >= 16 && cyc < 21)) rdy = 1'b0;
      else rdy = 1'($urandom & 1);
      step(idx < 8, enc(x), 1'(idx & 1), rdy, x);
      if (idx < 8 && in_if.ready) begin
        idx++;
        x = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc++;
    end
    check("bp_complete", (idx == 8 && exp_q.size() == 0), 1'b1);
    bp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset while full and stalled.
    for (int i = 0; i < LAT + 2; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, enc(x), 1'b1, bp_pat[i], x);
    end
    check("full_stalled", in_if.ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_if.valid = 1'b1;
    out_if.ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_if.valid = 1'b0;
    #1;
    check("rst2_out_valid", out_if.valid, 1'b0);
    check("rst2_out_data",  out_if.data, 128'h0);
    check("rst2_out_last",  out_if.last, 1'b0);
    check("rst2_in_ready",  in_if.ready, 1'b1);
    exp_q.delete();
    hold_prev = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, '0);
      check("post_rst_idle", out_if.valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
